// File: rtl/idct_wb_pkg.sv
// Shared types and constants for the IDCT block writeback engine: FSM states,
// plane selection, frame layout and request validation helpers.
package idct_wb_pkg;

    localparam int unsigned ADDR_W           = 18;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned S_W              = 32;
    localparam int unsigned PIX_W            = 8;
    localparam int unsigned DP_ADDR_W        = 6;
    localparam int unsigned ROW_W            = 5;
    localparam int unsigned COL_W            = 6;
    localparam int unsigned CLIP_CNT_W       = 7;
    localparam int unsigned BLOCK_DIM        = 8;
    localparam int unsigned PIXELS           = 64;
    localparam int unsigned MAX_BLOCK_ROW    = 29;
    localparam int unsigned MAX_Y_BLOCK_COL  = 39;
    localparam int unsigned MAX_UV_BLOCK_COL = 19;

    localparam logic [ADDR_W-1:0] Y_BASE = 18'd0;
    localparam logic [ADDR_W-1:0] U_BASE = 18'd38400;
    localparam logic [ADDR_W-1:0] V_BASE = 18'd57600;
    localparam logic [ADDR_W-1:0] Y_WPR  = 18'd160;
    localparam logic [ADDR_W-1:0] UV_WPR = 18'd80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_IN,
        S_RUN,
        S_LEAD_OUT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEG_Y       = 2'd0,
        SEG_U       = 2'd1,
        SEG_V       = 2'd2,
        SEG_INVALID = 2'd3
    } segment_t;

    typedef struct packed {
        segment_t          seg;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } block_req_t;

    function automatic logic [ADDR_W-1:0] plane_base(input segment_t seg);
        case (seg)
            SEG_U:   return U_BASE;
            SEG_V:   return V_BASE;
            default: return Y_BASE;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] plane_wpr(input segment_t seg);
        return (seg == SEG_Y) ? Y_WPR : UV_WPR;
    endfunction

    // Word address of the top-left pixel pair of the block.
    function automatic logic [ADDR_W-1:0] block_origin(input block_req_t req);
        return plane_base(req.seg)
             + ADDR_W'(req.row) * ADDR_W'(BLOCK_DIM) * plane_wpr(req.seg)
             + ADDR_W'({req.col, 2'b00});
    endfunction

    function automatic logic req_valid(input block_req_t req);
        logic [COL_W-1:0] max_col;
        max_col = (req.seg == SEG_Y) ? COL_W'(MAX_Y_BLOCK_COL) : COL_W'(MAX_UV_BLOCK_COL);
        return (req.seg != SEG_INVALID)
            && (req.row <= ROW_W'(MAX_BLOCK_ROW))
            && (req.col <= max_col);
    endfunction

endpackage

// File: rtl/pixel_clip8.sv
// Saturates a signed 32-bit IDCT sample to an unsigned 8-bit pixel and flags
// whether saturation occurred.
module pixel_clip8
    import idct_wb_pkg::*;
(
    input  logic signed [S_W-1:0]   s,
    output logic        [PIX_W-1:0] value_c,
    output logic                    sat_c
);

    always_comb begin
        value_c = s[PIX_W-1:0];
        sat_c   = 1'b0;
        if (s[S_W-1]) begin
            value_c = '0;
            sat_c   = 1'b1;
        end else if (|s[S_W-2:PIX_W]) begin
            value_c = '1;
            sat_c   = 1'b1;
        end
    end

endmodule

// File: rtl/idct_block_writeback.sv
// Streams one 8x8 block of IDCT samples from dual-port RAM, clips them and writes
// pixel pairs to SRAM. Define CLIP_COUNT_EN to add the per-block clip_count port.
module idct_block_writeback
    import idct_wb_pkg::*;
(
    input  logic                  CLOCK_50_I,
    input  logic                  resetn,
    input  logic                  Start,
    input  logic [1:0]            segment,
    input  logic [ROW_W-1:0]      block_row,
    input  logic [COL_W-1:0]      block_col,
    output logic [DP_ADDR_W-1:0]  DP_address,
    input  logic [S_W-1:0]        DP_read_data,
    output logic [ADDR_W-1:0]     SRAM_address,
    output logic [DATA_W-1:0]     SRAM_write_data,
    output logic                  SRAM_we_n,
    output logic                  Done
`ifdef CLIP_COUNT_EN
    ,
    output logic [CLIP_CNT_W-1:0] clip_count
`endif
);

    state_t               state, state_next;
    block_req_t           in_req;
    logic                 launch, fetch, consume, pair_next;
    logic [DP_ADDR_W-1:0] dp_addr_q;
    logic [DP_ADDR_W-1:0] pix_q;
    logic [PIX_W-1:0]     even_q;
    logic [ADDR_W-1:0]    origin_q, wpr_q, addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 we_n_q, done_q;
    logic [PIX_W-1:0]     clip_value;
    logic                 clip_sat;

    assign in_req.seg = segment_t'(segment);
    assign in_req.row = block_row;
    assign in_req.col = block_col;

    pixel_clip8 u_clip (
        .s       (DP_read_data),
        .value_c (clip_value),
        .sat_c   (clip_sat)
    );

    // State register.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next state and datapath strobes. pix_q indexes the sample currently on DP_read_data.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        fetch      = 1'b0;
        consume    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    launch     = 1'b1;
                    state_next = req_valid(in_req) ? S_LEAD_IN : S_DONE;
                end
            end
            S_LEAD_IN: begin
                fetch      = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                fetch   = 1'b1;
                consume = 1'b1;
                if (pix_q == DP_ADDR_W'(PIXELS - 2)) state_next = S_LEAD_OUT;
            end
            S_LEAD_OUT: begin
                consume    = 1'b1;
                state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // An even pixel arriving now means its pair is written next cycle.
    assign pair_next = consume && !pix_q[0];

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            dp_addr_q <= '0;
            pix_q     <= '0;
            even_q    <= '0;
            origin_q  <= '0;
            wpr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_n_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            if (launch) begin
                origin_q  <= block_origin(in_req);
                wpr_q     <= plane_wpr(in_req.seg);
                dp_addr_q <= '0;
                pix_q     <= '0;
            end
            if (fetch)   dp_addr_q <= dp_addr_q + 1'b1;
            if (consume) pix_q     <= pix_q + 1'b1;
            if (pair_next) begin
                even_q <= clip_value;
                addr_q <= origin_q + wpr_q * ADDR_W'(pix_q[5:3]) + ADDR_W'(pix_q[2:1]);
            end
            // Keep the written word so the bus holds it once the strobe drops.
            if (!we_n_q) wdata_q <= {even_q, clip_value};
            we_n_q <= !pair_next;
            done_q <= (state_next == S_DONE);
        end
    end

    // The odd pixel is only on DP_read_data during the write cycle, so it bypasses wdata_q.
    assign SRAM_write_data = we_n_q ? wdata_q : {even_q, clip_value};
    assign SRAM_address    = addr_q;
    assign SRAM_we_n       = we_n_q;
    assign DP_address      = dp_addr_q;
    assign Done            = done_q;

`ifdef CLIP_COUNT_EN
    logic [CLIP_CNT_W-1:0] clip_count_q;

    // Saturated pixels in the current block; frozen after the last pixel.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn)                  clip_count_q <= '0;
        else if (launch)              clip_count_q <= '0;
        else if (consume && clip_sat) clip_count_q <= clip_count_q + 1'b1;
    end

    assign clip_count = clip_count_q;
`else
    logic unused_clip_sat;
    assign unused_clip_sat = clip_sat;
`endif

endmodule
